// File: rtl/sram_arb_if.sv
// Bus bundle for sram_arb: fetch port, data port and SRAM-controller side.
// slave = the arbiter's view; master = the environment (requesters plus controller).
interface sram_arb_if;
  logic        if_req_i;
  logic [23:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [23:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;

  logic        timeout_o;

  logic        start_o;
  logic        rw_o;
  logic [23:0] addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic [31:0] rdata_i;
  logic        r_ready_i;
  logic        w_finish_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_ack_o, if_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    output d_ack_o, d_rdata_o,
    output timeout_o,
    output start_o, rw_o, addr_o, wdata_o, be_o,
    input  rdata_i, r_ready_i, w_finish_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_ack_o, if_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    input  d_ack_o, d_rdata_o,
    input  timeout_o,
    input  start_o, rw_o, addr_o, wdata_o, be_o,
    output rdata_i, r_ready_i, w_finish_i
  );
endinterface

// File: rtl/sram_arb.sv
// Two-port (fetch/data) arbiter in front of a single SRAM controller, with a BUSY timeout.
// Define SRAM_ARB_RR_EN for round-robin on simultaneous requests; default is data-over-fetch priority.
module sram_arb #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic       clk_i,
  input logic       rst_n_i,
  sram_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        owner_reg, owner_next;   // 1 = data port, 0 = fetch port
  logic        start_reg, start_next;
  logic        rw_reg, rw_next;
  logic [23:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  be_reg, be_next;
  logic        if_ack_reg, if_ack_next;
  logic        d_ack_reg, d_ack_next;
  logic        timeout_reg, timeout_next;
  logic [31:0] if_rdata_reg, if_rdata_next;
  logic [31:0] d_rdata_reg, d_rdata_next;

  logic grant_d;
  logic complete;

`ifdef SRAM_ARB_RR_EN
  // On a tie, the port that did not own the previous transaction wins.
  assign grant_d = bus.d_req_i & (~bus.if_req_i | ~owner_reg);
`else
  assign grant_d = bus.d_req_i;
`endif

  assign complete = rw_reg ? bus.r_ready_i : bus.w_finish_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'h0;
      owner_reg    <= 1'b0;
      start_reg    <= 1'b0;
      rw_reg       <= 1'b1;
      addr_reg     <= 24'h0;
      wdata_reg    <= 32'h0;
      be_reg       <= 4'h0;
      if_ack_reg   <= 1'b0;
      d_ack_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
      if_rdata_reg <= 32'h0;
      d_rdata_reg  <= 32'h0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      owner_reg    <= owner_next;
      start_reg    <= start_next;
      rw_reg       <= rw_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      be_reg       <= be_next;
      if_ack_reg   <= if_ack_next;
      d_ack_reg    <= d_ack_next;
      timeout_reg  <= timeout_next;
      if_rdata_reg <= if_rdata_next;
      d_rdata_reg  <= d_rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    owner_next    = owner_reg;
    start_next    = start_reg;
    rw_next       = rw_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    be_next       = be_reg;
    if_ack_next   = 1'b0;
    d_ack_next    = 1'b0;
    timeout_next  = 1'b0;
    if_rdata_next = if_rdata_reg;
    d_rdata_next  = d_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (bus.if_req_i || bus.d_req_i) begin
          owner_next = grant_d;
          start_next = 1'b1;
          cnt_next   = 4'h0;
          state_next = BUSY;
          if (grant_d) begin
            rw_next    = ~bus.d_we_i;
            addr_next  = bus.d_addr_i;
            wdata_next = bus.d_wdata_i;
            be_next    = bus.d_be_i;
          end else begin
            // Fetch is read-only and never carries write data or byte enables.
            rw_next    = 1'b1;
            addr_next  = bus.if_addr_i;
            wdata_next = 32'h0;
            be_next    = 4'h0;
          end
        end
      end

      BUSY: begin
        if (complete || cnt_reg == CNT_LAST) begin
          start_next   = 1'b0;
          timeout_next = ~complete;
          state_next   = DONE;
          if (owner_reg) d_ack_next  = 1'b1;
          else           if_ack_next = 1'b1;
          // An aborted read returns zero rather than stale controller data.
          if (rw_reg) begin
            if (owner_reg) d_rdata_next  = complete ? bus.rdata_i : 32'h0;
            else           if_rdata_next = complete ? bus.rdata_i : 32'h0;
          end
        end else begin
          cnt_next = cnt_reg + 4'h1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.start_o    = start_reg;
  assign bus.rw_o       = rw_reg;
  assign bus.addr_o     = addr_reg;
  assign bus.wdata_o    = wdata_reg;
  assign bus.be_o       = be_reg;
  assign bus.if_ack_o   = if_ack_reg;
  assign bus.d_ack_o    = d_ack_reg;
  assign bus.timeout_o  = timeout_reg;
  assign bus.if_rdata_o = if_rdata_reg;
  assign bus.d_rdata_o  = d_rdata_reg;

endmodule

// File: tb/tb_sram_arb.sv
// Directed self-checking bench for sram_arb; expectations are hand-computed per scenario.
module tb_sram_arb;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sram_arb_if bus ();

  sram_arb #(.TIMEOUT(15)) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (bus.start_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, 32'(bus.start_o), 32'h1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic exp_d [4];
  int   n_start;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = 24'h0;
    bus.d_req_i    = 1'b0;
    bus.d_we_i     = 1'b0;
    bus.d_addr_i   = 24'h0;
    bus.d_wdata_i  = 32'h0;
    bus.d_be_i     = 4'h0;
    bus.rdata_i    = 32'h0;
    bus.r_ready_i  = 1'b0;
    bus.w_finish_i = 1'b0;

`ifdef SRAM_ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_start", 32'(bus.start_o), 32'h0);
    check("rst_rw",    32'(bus.rw_o),    32'h1);
    check("rst_addr",  32'(bus.addr_o),  32'h0);
    check("rst_acks",  {30'h0, bus.if_ack_o, bus.d_ack_o}, 32'h0);
    check("rst_tmo",   32'(bus.timeout_o), 32'h0);
    check("rst_drd",   bus.d_rdata_o, 32'h0);
    $display("[TB] txn reset");
    rst_n = 1'b1;

    // Fetch read
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 24'h000010;
    @(negedge clk);
    check("fr_start", 32'(bus.start_o), 32'h1);
    check("fr_rw",    32'(bus.rw_o),    32'h1);
    check("fr_addr",  32'(bus.addr_o),  32'h000010);
    check("fr_wdbe",  {bus.wdata_o[27:0], bus.be_o}, 32'h0);
    @(negedge clk);
    check("fr_noack", 32'(bus.if_ack_o), 32'h0);
    bus.r_ready_i = 1'b1;
    bus.rdata_i   = 32'hDEADBEEF;
    @(negedge clk);
    check("fr_ack",   32'(bus.if_ack_o), 32'h1);
    check("fr_rdata", bus.if_rdata_o, 32'hDEADBEEF);
    check("fr_stlow", 32'(bus.start_o), 32'h0);
    bus.r_ready_i = 1'b0;
    bus.rdata_i   = 32'h0;
    bus.if_req_i  = 1'b0;
    @(negedge clk);
    check("fr_ack1",  32'(bus.if_ack_o), 32'h0);
    check("fr_hold",  bus.if_rdata_o, 32'hDEADBEEF);
    $display("[TB] txn fetch read addr=000010 rdata=%h", bus.if_rdata_o);

    // Data write, with a stray r_ready that must be ignored
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 24'h000020;
    bus.d_wdata_i = 32'h12345678;
    bus.d_be_i    = 4'b1100;
    @(negedge clk);
    check("dw_start", 32'(bus.start_o), 32'h1);
    check("dw_rw",    32'(bus.rw_o),    32'h0);
    check("dw_addr",  32'(bus.addr_o),  32'h000020);
    check("dw_wdata", bus.wdata_o,      32'h12345678);
    check("dw_be",    32'(bus.be_o),    32'hC);
    bus.r_ready_i = 1'b1;
    @(negedge clk);
    check("dw_rrign", {30'h0, bus.start_o, bus.d_ack_o}, 32'h2);
    bus.r_ready_i  = 1'b0;
    bus.w_finish_i = 1'b1;
    @(negedge clk);
    check("dw_ack",   32'(bus.d_ack_o), 32'h1);
    check("dw_rdata", bus.d_rdata_o,    32'h0);
    check("dw_tmo",   32'(bus.timeout_o), 32'h0);
    bus.w_finish_i = 1'b0;
    bus.d_req_i    = 1'b0;
    @(negedge clk);
    check("dw_ack1",  32'(bus.d_ack_o), 32'h0);
    $display("[TB] txn data write addr=000020 wdata=12345678");

    // Simultaneous requests, four transactions
    apply_reset();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 24'h000100;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 24'h000200;
    for (int i = 0; i < 4; i++) begin
      wait_start($sformatf("arb%0d", i));
      check($sformatf("arb%0d_owner", i), 32'(bus.addr_o),
            exp_d[i] ? 32'h000200 : 32'h000100);
      bus.r_ready_i = 1'b1;
      bus.rdata_i   = 32'hA0000000 + 32'(i);
      @(negedge clk);
      check($sformatf("arb%0d_ack", i), {30'h0, bus.if_ack_o, bus.d_ack_o},
            exp_d[i] ? 32'h1 : 32'h2);
      check($sformatf("arb%0d_rd", i), exp_d[i] ? bus.d_rdata_o : bus.if_rdata_o,
            32'hA0000000 + 32'(i));
      bus.r_ready_i = 1'b0;
      bus.rdata_i   = 32'h0;
      $display("[TB] txn arb %0d owner=%s", i, exp_d[i] ? "D" : "F");
    end
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Data read that never completes
    bus.d_req_i  = 1'b1;
    bus.d_we_i   = 1'b0;
    bus.d_addr_i = 24'h000030;
    wait_start("tmo");
    n_start = 0;
    while (bus.start_o === 1'b1 && n_start < 40) begin
      n_start++;
      @(negedge clk);
    end
    check("tmo_len",   32'(n_start), 32'd15);
    check("tmo_pulse", {30'h0, bus.timeout_o, bus.d_ack_o}, 32'h3);
    check("tmo_rdata", bus.d_rdata_o, 32'h0);
    bus.d_req_i = 1'b0;
    @(negedge clk);
    check("tmo_pulse1", {30'h0, bus.timeout_o, bus.d_ack_o}, 32'h0);
    $display("[TB] txn data read timeout after %0d cycles", n_start);

    // Reset during BUSY, request held across it
    @(negedge clk);
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 24'h000040;
    bus.d_wdata_i = 32'hCAFEF00D;
    bus.d_be_i    = 4'b0000;
    wait_start("rb");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rb_async", 32'(bus.start_o), 32'h0);
    @(negedge clk);
    check("rb_noack", {30'h0, bus.if_ack_o, bus.d_ack_o}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rb_regrant", {7'h0, bus.start_o, bus.addr_o}, 32'h01000040);
    check("rb_rw",      32'(bus.rw_o), 32'h0);
    bus.w_finish_i = 1'b1;
    @(negedge clk);
    check("rb_ack", 32'(bus.d_ack_o), 32'h1);
    bus.w_finish_i = 1'b0;
    bus.d_req_i    = 1'b0;
    @(negedge clk);
    $display("[TB] txn reset mid-busy, regrant addr=000040");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
